// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// widths and the program end marker.
package program_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2,
        ERROR   = 2'd3
    } loader_state_t;

    localparam int              DEF_NB_DATA         = 32;
    localparam int              DEF_NB_BYTE         = 8;
    localparam int              DEF_MEM_DEPTH_WORDS = 64;
    localparam logic [31:0]     DEF_HALT_WORD       = 32'hFFFF_FFFF;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian word assembler: keeps the leading bytes of the current word and
// the byte index; exposes the word that the incoming byte would complete.
module program_loader_word_assembler #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic [NB_BYTE-1:0] byte_in,
    output logic [NB_DATA-1:0] word_next,
    output logic               word_done
);
    localparam int BYTES = NB_DATA / NB_BYTE;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    // Only the bytes preceding the final one need storage; the final byte
    // arrives on the input in the same cycle the word is judged.
    logic [NB_DATA-NB_BYTE-1:0] partial;
    logic [IDX_W-1:0]           idx;

    assign word_next = {partial, byte_in};
    assign word_done = (idx == LAST_IDX);

    // Shift in accepted bytes; index wraps after the last byte of a word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            partial <= '0;
            idx     <= '0;
        end else if (clear) begin
            partial <= '0;
            idx     <= '0;
        end else if (shift) begin
            partial <= word_next[NB_DATA-NB_BYTE-1:0];
            idx     <= word_done ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: forwards UART bytes to instruction memory, counts words,
// stops on the halt word or flags overflow when memory is full.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                 NB_DATA         = DEF_NB_DATA,
    parameter int                 NB_BYTE         = DEF_NB_BYTE,
    parameter int                 MEM_DEPTH_WORDS = DEF_MEM_DEPTH_WORDS,
    parameter logic [NB_DATA-1:0] HALT_WORD       = DEF_HALT_WORD
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic [NB_BYTE-1:0]               i_rx_data,
    input  logic                             i_rx_valid,
    output logic [NB_BYTE-1:0]               o_byte_de_bootloader,
    output logic                             o_bootloader_write_enable,
    output logic                             o_pc_reset,
    output logic                             o_load_done,
    output logic                             o_overflow_error,
    output logic [$clog2(MEM_DEPTH_WORDS):0] o_word_count
);
    localparam int WC_W = $clog2(MEM_DEPTH_WORDS) + 1;
    localparam logic [WC_W-1:0] WC_FULL = WC_W'(MEM_DEPTH_WORDS);

    loader_state_t      state;
    logic               mem_full;
    logic               accept;
    logic [NB_DATA-1:0] word_next;
    logic               word_done;

    assign mem_full = (o_word_count == WC_FULL);
    // A byte is taken only while receiving, with room left, and no restart.
    assign accept   = (state == RECEIVE) && i_rx_valid && !i_start && !mem_full;

    program_loader_word_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_asm (
        .clk       (i_clk),
        .rst       (i_reset),
        .clear     (i_start),
        .shift     (accept),
        .byte_in   (i_rx_data),
        .word_next (word_next),
        .word_done (word_done)
    );

    // Load FSM with registered strobes, flags and word counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state                     <= IDLE;
            o_byte_de_bootloader      <= '0;
            o_bootloader_write_enable <= 1'b0;
            o_pc_reset                <= 1'b0;
            o_load_done               <= 1'b0;
            o_overflow_error          <= 1'b0;
            o_word_count              <= '0;
        end else begin
            o_bootloader_write_enable <= 1'b0;
            o_pc_reset                <= 1'b0;
            if (i_start) begin
                state            <= RECEIVE;
                o_load_done      <= 1'b0;
                o_overflow_error <= 1'b0;
                o_word_count     <= '0;
            end else begin
                case (state)
                    RECEIVE: begin
                        if (i_rx_valid) begin
                            if (mem_full) begin
                                state            <= ERROR;
                                o_overflow_error <= 1'b1;
                            end else begin
                                o_bootloader_write_enable <= 1'b1;
                                o_byte_de_bootloader      <= i_rx_data;
                                if (word_done) begin
                                    o_word_count <= o_word_count + WC_W'(1);
                                    if (word_next == HALT_WORD) begin
                                        state       <= DONE;
                                        o_pc_reset  <= 1'b1;
                                        o_load_done <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
